progmem_fetch: RTL and testbench

Byte-wide instruction prefetcher between the synchronous program memory and core0's decode stage. It streams sequential opcode bytes, each tagged with its program address, into a small FIFO ahead of the core. It flushes and redirects on a jump. It arbitrates the single program-memory port between fetch reads and core-issued program-memory writes.

---
 rtl/core0_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/progmem_fetch.sv | 135 +++++++++++++
 tb/tb_progmem_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core0_pkg.sv
// Shared types for core0's front end: opcode byte, program counter, and
// the {byte, pc} record carried through the fetch queue.
package core0_pkg;

    localparam int BYTE_W        = 8;
    localparam int PC_W_DEFAULT  = 8;

    typedef logic [BYTE_W-1:0]       byte_t;
    typedef logic [PC_W_DEFAULT-1:0] pc_t;

    // Queue record at the default program address width; wider or narrower
    // builds of the fetcher declare the same layout locally.
    typedef struct packed {
        byte_t opcode;
        pc_t   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched bytes: simultaneous push/pop,
// synchronous clear that wins over push/pop, and an occupancy count.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [PTR_W:0]   o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (PTR_W+1)'(DEPTH)) || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and count: clear empties the queue, otherwise push/pop move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/progmem_fetch.sv
// Byte-wide instruction prefetcher. Streams sequential opcode bytes tagged
// with their pc into a FIFO, redirects on jump, and shares the single
// program-memory port with core-issued writes (which flush and refetch).
module progmem_fetch
    import core0_pkg::*;
#(
    parameter int                          PROGRAM_ADDR_WIDTH = 8,
    parameter int                          FIFO_DEPTH         = 4,
    parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
    input  logic [7:0]                    programmem_read_value,
    output logic [7:0]                    programmem_write_value,
    output logic                          programmem_we,
    output logic                          instr_valid,
    output logic [7:0]                    instr_byte,
    output logic [PROGRAM_ADDR_WIDTH-1:0] instr_pc,
    input  logic                          instr_ready,
    input  logic                          jump,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] jump_addr,
    input  logic                          wr_req,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ack
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [PROGRAM_ADDR_WIDTH-1:0] addr_t;

    // Same layout as fetch_entry_t, sized to this instance's address width.
    typedef struct packed {
        byte_t opcode;
        addr_t pc;
    } entry_t;

    addr_t            r_fetch_pc;
    logic             r_inflight;
    addr_t            r_inflight_pc;

    entry_t           w_head;
    entry_t           w_push_entry;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occupancy;
    logic             w_valid;
    logic             w_pop;
    logic             w_jump;
    logic             w_wr_grant;
    logic             w_flush;
    logic             w_read;
    addr_t            w_restart_pc;

    // Everything is gated by reset so outputs sit at their idle values while held.
    assign w_jump       = jump & reset;
    assign w_wr_grant   = wr_req & ~jump & reset;
    assign w_flush      = w_jump | w_wr_grant;
    assign w_valid      = (w_count != '0);
    assign w_pop        = w_valid & instr_ready;

    // Slots committed after this cycle: queued minus popped plus the byte in flight.
    assign w_occupancy  = {1'b0, w_count} - {{CNT_W{1'b0}}, w_pop}
                        + {{CNT_W{1'b0}}, r_inflight};
    assign w_read       = reset & ~w_flush & (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign w_push_entry = '{opcode: programmem_read_value, pc: r_inflight_pc};

    // Restart point after a write: oldest byte the core has not consumed yet.
    always_comb begin
        w_restart_pc = r_fetch_pc;
        if (w_pop) begin
            w_restart_pc = w_head.pc + 1'b1;
        end else if (w_valid) begin
            w_restart_pc = w_head.pc;
        end else if (r_inflight) begin
            w_restart_pc = r_inflight_pc;
        end
    end

    // Memory port mux: jump target, then write, otherwise the sequential pc.
    always_comb begin
        programmem_addr = r_fetch_pc;
        if (w_jump) begin
            programmem_addr = jump_addr;
        end else if (w_wr_grant) begin
            programmem_addr = wr_addr;
        end
    end

    assign programmem_we          = w_wr_grant;
    assign wr_ack                 = w_wr_grant;
    assign programmem_write_value = w_wr_grant ? wr_data : 8'h00;

    assign instr_valid = w_valid;
    assign instr_byte  = w_valid ? w_head.opcode : 8'h00;
    assign instr_pc    = w_valid ? w_head.pc : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (w_flush),
        .i_push  (r_inflight),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Fetch pointer and in-flight tracking: jump redirects, write rewinds, read advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_jump) begin
            r_fetch_pc    <= jump_addr + 1'b1;
            r_inflight    <= 1'b1;
            r_inflight_pc <= jump_addr;
        end else if (w_wr_grant) begin
            r_fetch_pc    <= w_restart_pc;
            r_inflight    <= 1'b0;
        end else if (w_read) begin
            r_fetch_pc    <= r_fetch_pc + 1'b1;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_progmem_fetch.sv
// Bench for progmem_fetch: synchronous program memory, directed scenarios
// followed by random traffic, every cycle compared against a queue model.
module tb_progmem_fetch;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] programmem_addr;
    logic [7:0]    programmem_read_value;
    logic [7:0]    programmem_write_value;
    logic          programmem_we;
    logic          instr_valid;
    logic [7:0]    instr_byte;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;

    always #5 clk = ~clk;

    progmem_fetch #(
        .PROGRAM_ADDR_WIDTH (AW),
        .FIFO_DEPTH         (DEPTH),
        .RESET_PC           (8'h00)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .programmem_addr        (programmem_addr),
        .programmem_read_value  (programmem_read_value),
        .programmem_write_value (programmem_write_value),
        .programmem_we          (programmem_we),
        .instr_valid            (instr_valid),
        .instr_byte             (instr_byte),
        .instr_pc               (instr_pc),
        .instr_ready            (instr_ready),
        .jump                   (jump),
        .jump_addr              (jump_addr),
        .wr_req                 (wr_req),
        .wr_addr                (wr_addr),
        .wr_data                (wr_data),
        .wr_ack                 (wr_ack)
    );

    // Synchronous program memory, filled with random bytes on the first edge.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
            mem_ready <= 1'b1;
        end else if (programmem_we) begin
            mem[programmem_addr] <= programmem_write_value;
        end
        programmem_read_value <= mem[programmem_addr];
    end

    // Reference model: queue of {byte, pc} visible to the core, plus the
    // next fetch address and the one byte that may be travelling from memory.
    typedef struct {
        logic [7:0]    b;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] m_fpc;
    logic          m_infl;
    logic [AW-1:0] m_ipc;
    logic [7:0]    m_ib;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, n_cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        logic          ev;
        logic          pop;
        logic [7:0]    eb;
        logic [AW-1:0] ep;
        logic [AW-1:0] ea;
        logic          ewr;
        logic [7:0]    ewv;
        logic [AW-1:0] restart;
        int            room;
        if (!reset) begin
            q.delete();
            m_fpc  = 8'h00;
            m_infl = 1'b0;
            chk("rst_valid", instr_valid, 0);
            chk("rst_we",    programmem_we, 0);
            chk("rst_ack",   wr_ack, 0);
            chk("rst_addr",  programmem_addr, 0);
            chk("rst_wval",  programmem_write_value, 0);
            chk("rst_byte",  instr_byte, 0);
            chk("rst_pc",    instr_pc, 0);
            return;
        end
        ev  = (q.size() != 0);
        eb  = ev ? q[0].b  : 8'h00;
        ep  = ev ? q[0].pc : '0;
        pop = ev && instr_ready;
        ewr = !jump && wr_req;
        ewv = ewr ? wr_data : 8'h00;
        ea  = jump ? jump_addr : (ewr ? wr_addr : m_fpc);

        chk("valid", instr_valid, ev);
        chk("byte",  instr_byte, eb);
        chk("pc",    instr_pc, ep);
        chk("addr",  programmem_addr, ea);
        chk("we",    programmem_we, ewr);
        chk("ack",   wr_ack, ewr);
        chk("wval",  programmem_write_value, ewv);

        if (jump) begin
            q.delete();
            m_infl = 1'b1;
            m_ipc  = jump_addr;
            m_ib   = mem[jump_addr];
            m_fpc  = jump_addr + 8'd1;
        end else if (ewr) begin
            if (pop)          restart = q[0].pc + 8'd1;
            else if (ev)      restart = q[0].pc;
            else if (m_infl)  restart = m_ipc;
            else              restart = m_fpc;
            q.delete();
            m_infl = 1'b0;
            m_fpc  = restart;
        end else begin
            room = q.size() - int'(pop) + int'(m_infl);
            if (pop)    void'(q.pop_front());
            if (m_infl) q.push_back('{b: m_ib, pc: m_ipc});
            if (room < DEPTH) begin
                m_ipc  = m_fpc;
                m_ib   = mem[m_fpc];
                m_fpc  = m_fpc + 8'd1;
                m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic rdy, input logic jmp, input logic [7:0] ja,
                       input logic wq, input logic [7:0] wa, input logic [7:0] wd);
        instr_ready = rdy;
        jump        = jmp;
        jump_addr   = ja;
        wr_req      = wq;
        wr_addr     = wa;
        wr_data     = wd;
        @(negedge clk);
        model_step();
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_addr   = '0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;

        // Streaming with the core always ready.
        repeat (12) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Back-pressure until full, then drain.
        repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        repeat (8)  cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Jump while the queue holds bytes and a read is in flight.
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Jump and write together: write only granted on the next cycle.
        cyc(1'b1, 1'b1, 8'h20, 1'b1, 8'h30, 8'h5A);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h30, 8'h5A);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Self-modifying write to pc 6 while the head is pc 5 and held.
        cyc(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 8'hAA);
        repeat (6) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Write with a pop in the same cycle.
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 8'h11);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Address wrap across the top of program memory.
        cyc(1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 8'h00);
        repeat (6) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        // Random traffic in several mixes of ready/jump/write density.
        for (int ph = 0; ph < 4; ph++) begin
            int pr;
            int pj;
            int pw;
            pr = (ph == 0) ? 90 : (ph == 1) ? 40 : (ph == 2) ? 70 : 15;
            pj = (ph == 3) ? 2 : 6;
            pw = (ph == 2) ? 15 : 5;
            for (int k = 0; k < 600; k++) begin
                logic [7:0] ja;
                ja = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
                cyc($urandom_range(0, 99) < pr, $urandom_range(0, 99) < pj, ja,
                    $urandom_range(0, 99) < pw, 8'($urandom), 8'($urandom));
            end
        end

        // Reset in the middle of traffic discards everything.
        repeat (5) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;
        repeat (2) cyc(1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'h55);
        reset = 1'b1;
        repeat (10) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
